// File: rtl/alu_op_sequencer_if.sv
// Request, response and ALU-core signals for alu_op_sequencer.
// slave = the sequencer; master = the requester, response consumer and core around it.
interface alu_op_sequencer_if #(
   parameter int W = 16
);
   logic         req_valid;
   logic         req_ready;
   logic [3:0]   req_op;
   logic [W-1:0] req_m;
   logic [W-1:0] req_q;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_hi;
   logic [W-1:0] rsp_lo;
   logic [3:0]   rsp_flags;
   logic         rsp_err;
   logic         alu_start;
   logic [3:0]   alu_s;
   logic [W-1:0] alu_inbus;
   logic [W-1:0] alu_outbus;
   logic         alu_negative;
   logic         alu_zero;
   logic         alu_carry;
   logic         alu_overflow;
   logic         alu_finish;

   modport slave (
      input  req_valid, req_op, req_m, req_q, rsp_ready,
      input  alu_outbus, alu_negative, alu_zero, alu_carry, alu_overflow, alu_finish,
      output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_flags, rsp_err,
      output alu_start, alu_s, alu_inbus
   );

   modport master (
      output req_valid, req_op, req_m, req_q, rsp_ready,
      output alu_outbus, alu_negative, alu_zero, alu_carry, alu_overflow, alu_finish,
      input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_flags, rsp_err,
      input  alu_start, alu_s, alu_inbus
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front-end for the multi-cycle ALU core: issues start, time-multiplexes operands onto the
// core input bus, captures result words/flags at finish and returns them with a watchdog.
module alu_op_sequencer #(
   parameter int W       = 16,
   parameter int T_M     = 1,
   parameter int T_Q     = 2,
   parameter int HI_LAG  = 2,
   parameter int LO_LAG  = 1,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_b,
   alu_op_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

   state_t             state_q;
   logic [7:0]         k_q;
   logic [7:0]         k_d;
   logic [W-1:0]       m_q;
   logic [W-1:0]       q_q;
   logic [2:0][W-1:0]  hist_q;
   logic [3:0][W-1:0]  hv;
   logic [3:0]         flags_now;

   logic               req_ready_q;
   logic               alu_start_q;
   logic [3:0]         alu_s_q;
   logic [W-1:0]       alu_inbus_q;
   logic               rsp_valid_q;
   logic [W-1:0]       rsp_hi_q;
   logic [W-1:0]       rsp_lo_q;
   logic [3:0]         rsp_flags_q;
   logic               rsp_err_q;

   // hv[0] is this cycle's core output, hv[n] the core output n cycles ago
   assign hv        = {hist_q, bus.alu_outbus};
   assign flags_now = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
   assign k_d       = (k_q == 8'hFF) ? 8'hFF : k_q + 8'd1;

   function automatic logic [W-1:0] inbus_sel(input logic [7:0] k);
      if (k <= 8'(T_M))      return m_q;
      else if (k <= 8'(T_Q)) return q_q;
      else                   return '0;
   endfunction

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= IDLE;
         k_q         <= '0;
         m_q         <= '0;
         q_q         <= '0;
         hist_q      <= '0;
         req_ready_q <= 1'b1;
         alu_start_q <= 1'b0;
         alu_s_q     <= '0;
         alu_inbus_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_hi_q    <= '0;
         rsp_lo_q    <= '0;
         rsp_flags_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  m_q         <= bus.req_m;
                  q_q         <= bus.req_q;
                  k_q         <= '0;
                  req_ready_q <= 1'b0;
                  alu_start_q <= 1'b1;
                  alu_s_q     <= bus.req_op;
                  alu_inbus_q <= bus.req_m;
                  state_q     <= START;
               end
            end
            START: begin
               hist_q      <= {hist_q[1:0], bus.alu_outbus};
               k_q         <= 8'd1;
               alu_start_q <= 1'b0;
               alu_inbus_q <= inbus_sel(8'd1);
               state_q     <= BUSY;
            end
            BUSY: begin
               hist_q      <= {hist_q[1:0], bus.alu_outbus};
               k_q         <= k_d;
               alu_inbus_q <= inbus_sel(k_d);
               // finish has priority over a watchdog expiry in the same cycle
               if (bus.alu_finish) begin
                  rsp_hi_q    <= hv[HI_LAG];
                  rsp_lo_q    <= hv[LO_LAG];
                  rsp_flags_q <= flags_now;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  alu_s_q     <= '0;
                  alu_inbus_q <= '0;
                  state_q     <= RESP;
               end else if (k_q >= 8'(TIMEOUT)) begin
                  rsp_hi_q    <= '0;
                  rsp_lo_q    <= '0;
                  rsp_flags_q <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  alu_s_q     <= '0;
                  alu_inbus_q <= '0;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.alu_start = alu_start_q;
   assign bus.alu_s     = alu_s_q;
   assign bus.alu_inbus = alu_inbus_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_hi    = rsp_hi_q;
   assign bus.rsp_lo    = rsp_lo_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule
